// File: rtl/dmem_pkg.sv
// Shared encodings and request-decode helpers for the sized data memory.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Byte lanes touched by an access of the given size at byte offset a.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << a;
      SIZE_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: lane_mask = 4'b1111;
      default:   lane_mask = 4'b0000;
    endcase
  endfunction

  // Reserved size counts as misaligned so a single check covers both.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = a[0];
      SIZE_WORD: misaligned = (a != 2'b00);
      default:   misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extracts the addressed byte/halfword from a memory word and sign/zero extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  byte_f;
  logic [15:0] half_f;

  assign byte_f = word[{lane, 3'b000} +: 8];
  assign half_f = word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    data = word;
    case (size)
      SIZE_BYTE: data = {{24{~uns & byte_f[7]}}, byte_f};
      SIZE_HALF: data = {{16{~uns & half_f[15]}}, half_f};
      default:   data = word;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed little-endian data memory with sized loads/stores,
// a READ_LATENCY-deep load pipeline and a fault strobe for illegal requests.
module data_memory_sized
  import dmem_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Load,
  input  logic                  Store,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  LoadValid,
  output logic                  Fault
);

  localparam int STAGES = READ_LATENCY - 1;

  logic [3:0][7:0]        mem [DEPTH];
  logic [ADDR_WIDTH-3:0]  widx;
  logic                   illegal, wr_ok, rd_ok;
  logic [3:0]             we;
  logic [3:0][7:0]        wdata;
  logic [31:0]            ld_data;
  logic [STAGES:0]        vld_pipe;
  logic [STAGES:0][31:0]  dat_pipe;
  logic                   fault;

  assign widx    = Address[ADDR_WIDTH-1:2];
  assign illegal = (Load & Store) | misaligned(Size, Address[1:0]);
  assign wr_ok   = Store & ~illegal;
  assign rd_ok   = Load & ~illegal;
  assign we      = wr_ok ? lane_mask(Size, Address[1:0]) : 4'b0000;

  // Replicate store data so every lane sees its own slice at the right offset.
  always_comb begin
    wdata = DataIn;
    case (Size)
      SIZE_BYTE: wdata = {4{DataIn[7:0]}};
      SIZE_HALF: wdata = {2{DataIn[15:0]}};
      default:   wdata = DataIn;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we[b]) mem[widx][b] <= wdata[b];
  end

  dmem_load_align u_align (
    .word (mem[widx]),
    .lane (Address[1:0]),
    .size (Size),
    .uns  (Unsigned),
    .data (ld_data)
  );

  // Data is zeroed when invalid so DataOut reads 0 without an output mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
      fault    <= 1'b0;
    end else begin
      vld_pipe[0] <= rd_ok;
      dat_pipe[0] <= rd_ok ? ld_data : 32'h0;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
      fault <= (Load | Store) & illegal;
    end
  end

  assign LoadValid = vld_pipe[STAGES];
  assign DataOut   = dat_pipe[STAGES];
  assign Fault     = fault;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized at READ_LATENCY=3.
module tb_data_memory_sized;

  localparam int RL = 3;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          Load = 1'b0, Store = 1'b0, Unsigned = 1'b0;
  logic [1:0]    Size = 2'b00;
  logic [AW-1:0] Address = '0;
  logic [31:0]   DataIn = '0;
  logic [31:0]   DataOut;
  logic          LoadValid, Fault;

  int n_chk = 0;
  int n_pass = 0;

  data_memory_sized #(.DEPTH(1024), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n), .Load(Load), .Store(Store), .Size(Size),
    .Unsigned(Unsigned), .Address(Address), .DataIn(DataIn),
    .DataOut(DataOut), .LoadValid(LoadValid), .Fault(Fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic u,
                       input logic [AW-1:0] a, input logic [31:0] d);
    Load = ld; Store = st; Size = sz; Unsigned = u; Address = a; DataIn = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, '0, 32'h0);
  endtask

  task automatic store(input logic [1:0] sz, input logic [AW-1:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, sz, 1'b0, a, d);
    tick();
    idle();
    chk("store_nofault", {31'b0, Fault}, 32'h0);
  endtask

  task automatic load_check(input string tag, input logic [1:0] sz, input logic u,
                            input logic [AW-1:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, sz, u, a, 32'h0);
    tick();
    idle();
    for (int i = 0; i < RL - 1; i++) begin
      chk({tag, "_early"}, {31'b0, LoadValid}, 32'h0);
      tick();
    end
    chk({tag, "_vld"}, {31'b0, LoadValid}, 32'h1);
    chk(tag, DataOut, exp);
    tick();
    chk({tag, "_after"}, DataOut, 32'h0);
  endtask

  task automatic fault_check(input string tag, input logic ld, input logic st,
                             input logic [1:0] sz, input logic [AW-1:0] a, input logic [31:0] d);
    drive(ld, st, sz, 1'b0, a, d);
    tick();
    idle();
    chk({tag, "_fault"}, {31'b0, Fault}, 32'h1);
    for (int i = 0; i < RL + 1; i++) begin
      tick();
      if (i == 0) chk({tag, "_fault_end"}, {31'b0, Fault}, 32'h0);
      chk({tag, "_novld"}, {31'b0, LoadValid}, 32'h0);
    end
  endtask

  initial begin
    #12;
    chk("rst_dout", DataOut, 32'h0);
    chk("rst_vld", {31'b0, LoadValid}, 32'h0);
    chk("rst_fault", {31'b0, Fault}, 32'h0);
    rst_n = 1'b1;
    tick();

    store(2'b10, 12'h028, 32'hDEADBEEF);
    load_check("lw_028", 2'b10, 1'b0, 12'h028, 32'hDEADBEEF);

    store(2'b10, 12'h050, 32'h11223344);
    store(2'b00, 12'h051, 32'hAAAAAA80);
    load_check("lw_050", 2'b10, 1'b0, 12'h050, 32'h11228044);
    load_check("lb_051", 2'b00, 1'b0, 12'h051, 32'hFFFFFF80);
    load_check("lbu_051", 2'b00, 1'b1, 12'h051, 32'h00000080);
    load_check("lb_053", 2'b00, 1'b0, 12'h053, 32'h00000011);

    store(2'b10, 12'h060, 32'h00000000);
    store(2'b01, 12'h062, 32'h1234BEEF);
    load_check("lh_062", 2'b01, 1'b0, 12'h062, 32'hFFFFBEEF);
    load_check("lhu_062", 2'b01, 1'b1, 12'h062, 32'h0000BEEF);
    load_check("lw_060", 2'b10, 1'b0, 12'h060, 32'hBEEF0000);

    fault_check("lh_063", 1'b1, 1'b0, 2'b01, 12'h063, 32'h0);
    store(2'b10, 12'h020, 32'hCAFEF00D);
    fault_check("sw_022", 1'b0, 1'b1, 2'b10, 12'h022, 32'h12345678);
    load_check("lw_020_a", 2'b10, 1'b0, 12'h020, 32'hCAFEF00D);
    fault_check("ld_st", 1'b1, 1'b1, 2'b10, 12'h020, 32'h55555555);
    load_check("lw_020_b", 2'b10, 1'b0, 12'h020, 32'hCAFEF00D);
    fault_check("size11", 1'b1, 1'b0, 2'b11, 12'h020, 32'h0);

    // Back-to-back loads
    store(2'b10, 12'h000, 32'h11110000);
    store(2'b10, 12'h004, 32'h22220004);
    store(2'b10, 12'h008, 32'h33330008);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0); tick();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 12'h004, 32'h0); tick();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 12'h008, 32'h0); tick();
    idle();
    chk("b2b0_vld", {31'b0, LoadValid}, 32'h1);
    chk("b2b0", DataOut, 32'h11110000);
    tick();
    chk("b2b1_vld", {31'b0, LoadValid}, 32'h1);
    chk("b2b1", DataOut, 32'h22220004);
    tick();
    chk("b2b2_vld", {31'b0, LoadValid}, 32'h1);
    chk("b2b2", DataOut, 32'h33330008);
    tick();
    chk("b2b_end", {31'b0, LoadValid}, 32'h0);

    // Reset in the middle of two in-flight loads
    drive(1'b1, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0); tick();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 12'h004, 32'h0); tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk("mrst_dout", DataOut, 32'h0);
    chk("mrst_vld", {31'b0, LoadValid}, 32'h0);
    chk("mrst_fault", {31'b0, Fault}, 32'h0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < RL + 1; i++) begin
      tick();
      chk("mrst_novld", {31'b0, LoadValid}, 32'h0);
    end

    // Store then load on the next edge sees new data
    store(2'b10, 12'h010, 32'hAAAA5555);
    load_check("raw_010", 2'b10, 1'b0, 12'h010, 32'hAAAA5555);

    // Load then store on the next edge: load returns old data
    drive(1'b1, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0); tick();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 12'h010, 32'h77778888); tick();
    idle();
    tick();
    chk("war_vld", {31'b0, LoadValid}, 32'h1);
    chk("war_old", DataOut, 32'hAAAA5555);
    tick();
    load_check("war_new", 2'b10, 1'b0, 12'h010, 32'h77778888);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
